// File: rtl/logic_bist_pkg.sv
// Shared types and MISR step function for the exhaustive-pattern logic BIST controller.
package logic_bist_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} bist_state_t;

  localparam logic [15:0] DEF_POLY   = 16'h1021;
  localparam logic [15:0] DEF_SEED   = 16'h0000;
  localparam int          MISR_MAX_W = 32;

  // Width-generic MISR step: callers zero-extend into 32 bits and truncate the result.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] poly,
                                            input logic [31:0] din,
                                            input int          sig_w);
    logic [31:0] mask;
    logic [31:0] fb;
    mask = (sig_w >= MISR_MAX_W) ? 32'hFFFF_FFFF : ((32'd1 << sig_w) - 32'd1);
    fb   = (|(sig & (32'd1 << (sig_w - 1)))) ? poly : 32'd0;
    return ((sig << 1) ^ fb ^ din) & mask;
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register; clear loads SEED, en folds din into the signature.
module bist_misr
  import logic_bist_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter int               N_OUT = 1,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [N_OUT-1:0] din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;

  assign sig_d = SIG_W'(misr_next(32'(sig_q), 32'(POLY), 32'(din), SIG_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SEED;
    end else if (clear) begin
      sig_q <= SEED;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/logic_bist_ctrl.sv
// Exhaustive-vector logic BIST controller: walks all 2^N_IN inputs, settles, compresses outputs.
// Optional golden-signature compare enabled by BIST_GOLDEN_EN.
//
// state  | meaning
// IDLE   | waiting for start, outputs hold
// SETTLE | vector applied, counting SETTLE_CYC cycles of settle time
// SAMPLE | one cycle: DUT response folded into the MISR
// DONE   | one cycle: done pulse, start here restarts immediately
module logic_bist_ctrl
  import logic_bist_pkg::*;
#(
  parameter int               N_IN       = 6,
  parameter int               N_OUT      = 1,
  parameter int               SETTLE_CYC = 3,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED       = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [N_IN-1:0]  vec_cnt,
  output logic [SIG_W-1:0] signature
`ifdef BIST_GOLDEN_EN
  ,
  input  logic [SIG_W-1:0] golden_sig,
  output logic             pass
`endif
);

  localparam logic [N_IN-1:0] VEC_LAST    = '1;
  localparam logic [7:0]      SETTLE_LAST = (SETTLE_CYC == 0) ? 8'd0 : 8'(SETTLE_CYC - 1);
  localparam bist_state_t     RUN_ENTRY   = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;

  bist_state_t     state_q;
  logic [N_IN-1:0] vec_q;
  logic [7:0]      settle_q;
  logic            busy_q;
  logic            done_q;
  logic            launch;
  logic            misr_en;

  // abort wins over start in every state, and suppresses a sample in flight
  assign launch  = ((state_q == IDLE) || (state_q == DONE)) && start && !abort;
  assign misr_en = (state_q == SAMPLE) && !abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (launch) begin
            state_q  <= RUN_ENTRY;
            vec_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (settle_q == SETTLE_LAST) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        SAMPLE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (vec_q == VEC_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q  <= RUN_ENTRY;
            vec_q    <= vec_q + 1'b1;
            settle_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  bist_misr #(
    .SIG_W (SIG_W),
    .N_OUT (N_OUT),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (launch),
    .en    (misr_en),
    .din   (dut_out),
    .sig   (signature)
  );

`ifdef BIST_GOLDEN_EN
  logic pass_q;

  // the signature is final during DONE, so the compare lands one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else if (launch) begin
      pass_q <= 1'b0;
    end else if (state_q == DONE) begin
      pass_q <= (signature == golden_sig);
    end
  end

  assign pass = pass_q;
`endif

  assign dut_in  = vec_q;
  assign vec_cnt = vec_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/logic_bist_ctrl.md
Name: logic_bist_ctrl

Overview:
- Parametrised on-chip replacement for hand-written stimulus benches on small combinational circuits.
- Drives every input combination of an N_IN-input combinational DUT in exhaustive binary order.
- Waits a programmable settle time for gate delays, then compresses DUT outputs into a MISR signature.
- Sits beside the DUT under test; its signature is compared against a golden value.

Parameters:
- N_IN, 6, DUT input count; vectors 0 .. 2^N_IN-1 (range 1..16).
- N_OUT, 1, DUT output count (1..SIG_W).
- SETTLE_CYC, 3, cycles to wait after applying a vector before sampling (0..255).
- SIG_W, 16, MISR width.
- POLY, 16'h1021, MISR feedback polynomial (SIG_W bits).
- SEED, 0, MISR value after reset/start.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; accepted only in IDLE or DONE
- abort  in  1  stop a run; return to IDLE
- dut_in  out  N_IN  stimulus to DUT
- dut_out  in  N_OUT  DUT response
- busy  out  1  high in SETTLE/SAMPLE
- done  out  1  one-cycle pulse after last vector sampled
- vec_cnt  out  N_IN  current vector index (equals dut_in)
- signature  out  SIG_W  MISR contents

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; dut_in=0, vec_cnt=0, busy=0, done=0, signature=SEED, settle counter=0. Reset overrides start/abort in the same cycle; reset mid-run drops straight to IDLE.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: outputs hold. On start go to SETTLE; vec_cnt=0, signature=SEED, settle counter=0. If SETTLE_CYC==0, go directly to SAMPLE.
- SETTLE: dut_in stable. Counter increments each cycle; after exactly SETTLE_CYC cycles in SETTLE, go to SAMPLE.
- SAMPLE (1 cycle): signature <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extend(dut_out).
  - If vec_cnt == 2^N_IN-1, go to DONE; vec_cnt holds.
  - Else vec_cnt+1 and back to SETTLE (or SAMPLE if SETTLE_CYC==0).
- DONE (1 cycle): done=1, busy=0, then IDLE. start in DONE is accepted and behaves as start in IDLE; done still pulses.
- Timing: busy high for exactly 2^N_IN*(SETTLE_CYC+1) cycles starting the cycle after start is sampled.
- Signature holds after DONE until the next start or reset.
- start while busy is ignored.
- abort while busy: next state IDLE, no done pulse, signature/vec_cnt freeze at partial values. abort has priority over start.
- vec_cnt wrap: never wraps; the terminal compare ends the run. N_IN-bit arithmetic, no carry out.
- dut_in changes only on SETTLE entry, so the DUT sees each vector for SETTLE_CYC+1 cycles.

Optional Feature:
- Macro: BIST_GOLDEN_EN.
- When defined:
  - Adds input golden_sig [SIG_W] and output pass [1].
  - In DONE, pass <= (signature == golden_sig); pass holds until the next start (cleared to 0) or reset (0).
  - An aborted run leaves pass=0.
- When undefined: neither port exists; no compare logic.

Decomposition:
- Package logic_bist_pkg: state enum (IDLE, SETTLE, SAMPLE, DONE), default POLY/SEED constants, and the misr_next function (SIG_W/N_OUT generic via parameters of the caller).
- One sub-module: bist_misr (parametrised SIG_W, N_OUT, POLY, SEED), with ports clk, rst, clear, en, din, sig.
- FSM and counters stay in logic_bist_ctrl.

Test Plan:
- Common config for the first four: N_IN=2, N_OUT=1, SIG_W=4, POLY=4'h3, SEED=0, SETTLE_CYC=2.
- DUT = 2-input AND; start pulse -> dut_in 0,1,2,3, each held 3 cycles; busy 12 cycles; done pulse at cycle 13; signature=4'h1.
- DUT = 2-input XOR -> signature=4'h6. With BIST_GOLDEN_EN and golden_sig=4'h6 -> pass=1; with golden_sig=4'h1 -> pass=0.
- AND DUT, abort asserted while vec_cnt=2 in SETTLE -> IDLE next cycle, no done, vec_cnt=2, signature=4'h0. A following start reruns to signature=4'h1.
- rst asserted mid-run together with start -> dut_in=0, busy=0, signature=SEED next cycle. start while busy -> run length is unchanged (12 cycles).
- N_IN=6, SETTLE_CYC=0, 6-input DUT with 3-gate-delay behavioural model -> busy exactly 64 cycles. Back-to-back start in the DONE cycle restarts immediately with an identical signature.
